mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 data mux (the `mux4to1` tree of `mux2to1` cells). Four requesters each present a request and a data word. The block grants exclusive ownership of the mux to one requester at a time, drives the select, and registers the selected word with a valid strobe. It sits between requesting sources and the single downstream consumer of the mux output.

## Interface
- `WIDTH`, 8: data width of each input word and of `out_data`.
- `MAX_BURST`, 8: maximum consecutive grant cycles per ownership when the burst limit is compiled in; legal range ≥ 1.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  per-requester request; bit i belongs to requester i.
- `in_data`  input  4*WIDTH  packed words; requester i at bits [i*WIDTH +: WIDTH].
- `grant`  output  4  one-hot (or zero) ownership indication, registered.
- `sel`  output  2  mux select of current owner, registered.
- `busy`  output  1  high while in GRANT state.
- `out_data`  output  WIDTH  registered mux output.
- `out_valid`  output  1  `out_data` holds a word from the current owner.

## Operation
- Reset values: `grant`=0, `sel`=0, `busy`=0, `out_data`=0, `out_valid`=0, last-grant pointer `ptr`=3, burst counter=0, state IDLE.
- States: IDLE, GRANT.
- IDLE: if any `req` bit is high, pick the first set bit searching `ptr+1, ptr+2, …` modulo 4. Load `grant`, `sel`, and `ptr` with the winner. Clear the burst counter. Go to GRANT. With no request, stay in IDLE with `grant`=0.
- GRANT, owner request high and not at limit: stay; increment the burst counter. `out_data` ← `in_data[sel]` and `out_valid` ← 1.
- GRANT, owner request low: `out_valid` ← 0, `grant` ← 0, go to IDLE. `sel` holds its last value.
- GRANT, burst limit reached (macro on): the cycle with counter = MAX_BURST−1 is the last captured word. At the next edge, release exactly as for a dropped request.
- After any release, the block spends exactly one IDLE cycle (`grant`=0) before the next grant. Re-arbitration uses the updated `ptr`, so the previous owner has lowest priority.
- Requests from non-owners never disturb an active grant.
- `in_data` of non-owners is ignored.

## Timing
- Request high before edge k → `grant`/`sel`/`busy` valid after edge k. First `out_data`/`out_valid` appear after edge k+1. Grant-to-data latency is 1 cycle.
- Owner drops `req` before edge m → after edge m, `out_valid`=0 and `grant`=0. The word presented at edge m is not captured.
- Burst counter width is $clog2(MAX_BURST+1). It saturates and never wraps.
- `rst` high at any edge, including mid-grant, forces all reset values after that edge. No partial word is emitted.
- `grant` is never multi-hot. `out_valid` is never high while `grant`=0.

## Configuration
- `MUX4_ARB_BURST_LIMIT_EN` defined: an ownership ends after at most MAX_BURST valid words, even if the owner's `req` stays high. The owner may re-win only through normal round-robin.
- Undefined: an ownership lasts while the owner's `req` is high. The burst counter and the `MAX_BURST` compare are not synthesized, and `MAX_BURST` is ignored.

## Structure
- Shared package `mux_arb_pkg`: `NUM_REQ`=4, `SEL_W`=2, and the state enum `{ST_IDLE, ST_GRANT}`.
- One sub-module: the existing `mux4to1`, instantiated per bit (or WIDTH-wide), driven by registered `sel`. Its output feeds the `out_data` register.
- Round-robin search is local combinational logic; it needs no separate module.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles → `grant`=0, `out_valid`=0, `out_data`=0 throughout.
- `req`=4'b1111, `in_data` words {0x33,0x22,0x11,0x00}, held 40 cycles, macro on, MAX_BURST=4 → grants in order 0,1,2,3,0. Each grant gives 4 valid words, separated by one idle cycle.
- Same stimulus with macro off → requester 0 holds the grant indefinitely, with `out_data`=0x00 valid every cycle after the first.
- Requester 2 alone for 3 cycles, then drops → `grant`=4'b0100 for 3 cycles, 2 valid words of 0x22, then `grant`=0. Next `req`=4'b0101 grants requester 0 (ptr=2 → search 3,0).
- Mid-grant of requester 1, assert `rst` for one edge → all outputs at reset values after that edge. Next grant with `req`=4'b1111 goes to requester 0.
- Owner request and a new non-owner request change in the same cycle → the owner releases and the idle cycle occurs. The new requester is granted only at the following edge, never on the release edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
// Requester count, select width, FSM state encoding and the round-robin
// winner search used by mux4_rr_arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Round-robin pick: first set request bit searching ptr+1, ptr+2, ...
    // modulo NUM_REQ. Scanning from the farthest candidate down to the
    // nearest lets the nearest set bit overwrite the result last.
    // Returns ptr when no bit is set; callers only use it when |req.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            // k = NUM_REQ truncates to 0 and wraps back to ptr itself
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux4to1.sv
// Shared 4:1 data mux, built as a two-level tree of 2:1 selections.
// sel[0] picks within each pair, sel[1] picks between the pairs.
module mux4to1 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    // First tree level: one 2:1 cell per input pair
    always_comb begin
        w_lo = i_sel[0] ? i_d1 : i_d0;
        w_hi = i_sel[0] ? i_d3 : i_d2;
    end

    // Second tree level: choose between the pairs
    always_comb begin
        o_y = i_sel[1] ? w_hi : w_lo;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 data mux.
// Grants the mux to one requester at a time, drives the registered select
// and registers the selected word with a valid strobe.
// Optional feature: define MUX4_ARB_BURST_LIMIT_EN to end each ownership
// after at most MAX_BURST valid words; undefined, MAX_BURST is ignored.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SEL_W-1:0]         sel,
    output logic                     busy,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid
);

    // MAX_BURST must be at least 1; a zero or negative value has no legal
    // meaning, so this elaboration branch exists only to name that range.
    if (MAX_BURST < 1) begin : g_max_burst_out_of_range
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_grant_nxt;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [SEL_W-1:0]      r_ptr;
    logic [SEL_W-1:0]      w_ptr_nxt;
    logic [WIDTH-1:0]      r_out_data;
    logic [WIDTH-1:0]      w_out_data_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;
    logic [SEL_W-1:0]      w_winner;
    logic [WIDTH-1:0]      w_mux_y;
    logic                  w_at_limit;

`ifdef MUX4_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0]      r_burst_cnt;
    logic [CNT_W-1:0]      w_burst_cnt_nxt;

    // Ownership ends once MAX_BURST words have been captured
    always_comb begin
        w_at_limit = (r_burst_cnt == CNT_W'(MAX_BURST));
    end
`else
    // Without the burst limit an ownership lasts while its request is high
    always_comb begin
        w_at_limit = 1'b0;
    end
`endif

    // Shared data mux, steered by the registered select of the owner
    mux4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_sel (r_sel),
        .i_d0  (in_data[0*WIDTH +: WIDTH]),
        .i_d1  (in_data[1*WIDTH +: WIDTH]),
        .i_d2  (in_data[2*WIDTH +: WIDTH]),
        .i_d3  (in_data[3*WIDTH +: WIDTH]),
        .o_y   (w_mux_y)
    );

    // Round-robin winner relative to the last-granted pointer
    always_comb begin
        w_winner = rr_pick(req, r_ptr);
    end

    // Next-state and next-output logic of the IDLE/GRANT sequencer
    always_comb begin
        // NOTE: every signal gets a hold/default value first so that no
        // path through the case leaves it unassigned (no latch inferred).
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
`ifdef MUX4_ARB_BURST_LIMIT_EN
        w_burst_cnt_nxt = r_burst_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|req) begin
                    w_grant_nxt     = NUM_REQ'(1) << w_winner;
                    w_sel_nxt       = w_winner;
                    w_ptr_nxt       = w_winner;
                    w_state_nxt     = ST_GRANT;
`ifdef MUX4_ARB_BURST_LIMIT_EN
                    w_burst_cnt_nxt = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (req[r_sel] && !w_at_limit) begin
                    w_out_data_nxt  = w_mux_y;
                    w_out_valid_nxt = 1'b1;
`ifdef MUX4_ARB_BURST_LIMIT_EN
                    // Increments only below the limit, so it saturates
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
`endif
                end else begin
                    // Release: sel keeps its last value, one IDLE cycle follows
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: every register here has a defined reset value because the
        // outputs must show known values immediately after reset.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_sel       <= '0;
            r_ptr       <= SEL_W'(NUM_REQ - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

`ifdef MUX4_ARB_BURST_LIMIT_EN
    // Burst counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end
`endif

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign busy      = (r_state == ST_GRANT);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
